// File: rtl/veriboy_pkg.sv
// Shared definitions for the CPU core: stack-transfer states, register-file
// write encodings, register indices and stack/flag constants.
package veriboy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StPushHi,
    StPushLo,
    StPopLo,
    StPopHi,
    StDone
  } xfer_state_e;

  // Register-file write-enable encoding
  localparam logic [1:0] WE_NONE = 2'd0;
  localparam logic [1:0] WE_BYTE = 2'd1;
  localparam logic [1:0] WE_PAIR = 2'd2;

  // Register-file indices; a pair is addressed by its high-byte index
  localparam logic [3:0] REG_B = 4'd0;
  localparam logic [3:0] REG_C = 4'd1;
  localparam logic [3:0] REG_D = 4'd2;
  localparam logic [3:0] REG_E = 4'd3;
  localparam logic [3:0] REG_H = 4'd4;
  localparam logic [3:0] REG_L = 4'd5;
  localparam logic [3:0] REG_A = 4'd6;
  localparam logic [3:0] REG_F = 4'd7;

  localparam logic OP_PUSH = 1'b0;
  localparam logic OP_POP  = 1'b1;

  localparam logic [15:0] SP_RESET_DEFAULT = 16'hFFFE;

  // Only the upper nibble of F is architecturally defined
  localparam logic [7:0] FLAG_MASK = 8'hF0;

endpackage

// File: rtl/stack_xfer_unit.sv
// Sequences PUSH/POP of a 16-bit register pair over the 8-bit memory bus and
// owns the stack pointer. All outputs are registered.
module stack_xfer_unit
  import veriboy_pkg::*;
#(
  parameter logic [15:0] SP_RESET = SP_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        op,
  input  logic [3:0]  pair,
  input  logic        is_af,
  input  logic [7:0]  pair_hi,
  input  logic [7:0]  pair_lo,
  input  logic [7:0]  flags_in,
  output logic        busy,
  output logic        done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  input  logic        mem_ack,
  output logic [1:0]  reg_wr_en,
  output logic [3:0]  reg_wr_idx,
  output logic [15:0] reg_wr_data,
  output logic        flag_wr,
  output logic [7:0]  flag_wr_data,
  input  logic        sp_wr,
  input  logic [15:0] sp_wr_data,
  output logic [15:0] sp
);

  xfer_state_e state_q, state_d;
  logic [15:0] sp_q, sp_d;
  logic [7:0]  hi_q, hi_d, lo_q, lo_d;
  logic        op_q, op_d, is_af_q, is_af_d;
  logic [3:0]  pair_q, pair_d;

  logic        busy_q, busy_d, done_q, done_d;
  logic        mem_req_q, mem_req_d, mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic [1:0]  reg_wr_en_q, reg_wr_en_d;
  logic [3:0]  reg_wr_idx_q, reg_wr_idx_d;
  logic [15:0] reg_wr_data_q, reg_wr_data_d;
  logic        flag_wr_q, flag_wr_d;
  logic [7:0]  flag_wr_data_q, flag_wr_data_d;

  // Next-state and sequencing
  always_comb begin
    state_d = state_q;
    sp_d    = sp_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    op_d    = op_q;
    pair_d  = pair_q;
    is_af_d = is_af_q;

    unique case (state_q)
      StIdle: begin
        // An SP load in the same cycle as start is seen by the new operation
        if (sp_wr) sp_d = sp_wr_data;
        if (start) begin
          op_d    = op;
          pair_d  = pair;
          is_af_d = is_af;
          hi_d    = pair_hi;
          lo_d    = is_af ? flags_in : pair_lo;
          state_d = (op == OP_POP) ? StPopLo : StPushHi;
        end
      end
      StPushHi: begin
        if (mem_ack) begin
          sp_d    = sp_q - 16'd1;
          state_d = StPushLo;
        end
      end
      StPushLo: begin
        if (mem_ack) begin
          sp_d    = sp_q - 16'd1;
          state_d = StDone;
        end
      end
      StPopLo: begin
        if (mem_ack) begin
          lo_d    = mem_rdata;
          sp_d    = sp_q + 16'd1;
          state_d = StPopHi;
        end
      end
      StPopHi: begin
        if (mem_ack) begin
          hi_d    = mem_rdata;
          sp_d    = sp_q + 16'd1;
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Output values for the coming cycle, derived from the next state
  always_comb begin
    busy_d         = (state_d != StIdle);
    done_d         = (state_d == StDone);
    mem_req_d      = 1'b0;
    mem_we_d       = 1'b0;
    mem_addr_d     = 16'h0000;
    mem_wdata_d    = 8'h00;
    reg_wr_en_d    = WE_NONE;
    reg_wr_idx_d   = 4'h0;
    reg_wr_data_d  = 16'h0000;
    flag_wr_d      = 1'b0;
    flag_wr_data_d = 8'h00;

    unique case (state_d)
      StPushHi: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_d - 16'd1;
        mem_wdata_d = hi_d;
      end
      StPushLo: begin
        mem_req_d   = 1'b1;
        mem_we_d    = 1'b1;
        mem_addr_d  = sp_d - 16'd1;
        mem_wdata_d = lo_d;
      end
      StPopLo, StPopHi: begin
        mem_req_d  = 1'b1;
        mem_addr_d = sp_d;
      end
      StDone: begin
        if (op_d == OP_POP) begin
          reg_wr_idx_d = pair_d;
          if (is_af_d) begin
            reg_wr_en_d    = WE_BYTE;
            reg_wr_data_d  = {8'h00, hi_d};
            flag_wr_d      = 1'b1;
            flag_wr_data_d = lo_d & FLAG_MASK;
          end else begin
            reg_wr_en_d   = WE_PAIR;
            reg_wr_data_d = {hi_d, lo_d};
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= StIdle;
      sp_q           <= SP_RESET;
      hi_q           <= 8'h00;
      lo_q           <= 8'h00;
      op_q           <= 1'b0;
      pair_q         <= 4'h0;
      is_af_q        <= 1'b0;
      busy_q         <= 1'b0;
      done_q         <= 1'b0;
      mem_req_q      <= 1'b0;
      mem_we_q       <= 1'b0;
      mem_addr_q     <= 16'h0000;
      mem_wdata_q    <= 8'h00;
      reg_wr_en_q    <= WE_NONE;
      reg_wr_idx_q   <= 4'h0;
      reg_wr_data_q  <= 16'h0000;
      flag_wr_q      <= 1'b0;
      flag_wr_data_q <= 8'h00;
    end else begin
      state_q        <= state_d;
      sp_q           <= sp_d;
      hi_q           <= hi_d;
      lo_q           <= lo_d;
      op_q           <= op_d;
      pair_q         <= pair_d;
      is_af_q        <= is_af_d;
      busy_q         <= busy_d;
      done_q         <= done_d;
      mem_req_q      <= mem_req_d;
      mem_we_q       <= mem_we_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      reg_wr_en_q    <= reg_wr_en_d;
      reg_wr_idx_q   <= reg_wr_idx_d;
      reg_wr_data_q  <= reg_wr_data_d;
      flag_wr_q      <= flag_wr_d;
      flag_wr_data_q <= flag_wr_data_d;
    end
  end

  assign busy         = busy_q;
  assign done         = done_q;
  assign mem_req      = mem_req_q;
  assign mem_we       = mem_we_q;
  assign mem_addr     = mem_addr_q;
  assign mem_wdata    = mem_wdata_q;
  assign reg_wr_en    = reg_wr_en_q;
  assign reg_wr_idx   = reg_wr_idx_q;
  assign reg_wr_data  = reg_wr_data_q;
  assign flag_wr      = flag_wr_q;
  assign flag_wr_data = flag_wr_data_q;
  assign sp           = sp_q;

endmodule
